// File: rtl/minmax_reduce_seq.sv
// minmax_reduce_seq: streaming signed min/max reduction over len elements with a held result.
// Define MINMAX_REDUCE_ARGIDX_EN to add out_idx, the arrival index of the winning element.
module minmax_reduce_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_max,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef MINMAX_REDUCE_ARGIDX_EN
  ,
  output logic [CNT_W-1:0] out_idx
`endif
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN_ID = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_ID = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic mode_q, mode_d, accept, better;
`ifdef MINMAX_REDUCE_ARGIDX_EN
  logic [CNT_W-1:0] idx_q, idx_d;
  assign out_idx = idx_q;
`endif
  assign accept = (state_q == ACCUM) && in_valid;
  // strict compare keeps the earlier element on ties
  assign better = mode_q ? ($signed(in_data) > $signed(acc_q)) : ($signed(in_data) < $signed(acc_q));
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    mode_d = mode_q;
`ifdef MINMAX_REDUCE_ARGIDX_EN
    idx_d = idx_q;
`endif
    if (state_q == IDLE && start) begin
      state_d = (len == '0) ? DONE : ACCUM;
      acc_d = mode_max ? MAX_ID : MIN_ID;
      cnt_d = '0;
      len_d = len;
      mode_d = mode_max;
`ifdef MINMAX_REDUCE_ARGIDX_EN
      idx_d = '0;
`endif
    end else if (accept) begin
      acc_d = better ? in_data : acc_q;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_d == len_q) ? DONE : ACCUM;
`ifdef MINMAX_REDUCE_ARGIDX_EN
      idx_d = better ? cnt_q : idx_q;
`endif
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
`ifdef MINMAX_REDUCE_ARGIDX_EN
      idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      mode_q <= mode_d;
`ifdef MINMAX_REDUCE_ARGIDX_EN
      idx_q <= idx_d;
`endif
    end
  end
  assign in_ready = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy = (state_q != IDLE);
  assign out_data = acc_q;
endmodule

// File: doc/minmax_reduce_seq.md
MINMAX_REDUCE_SEQ -- requirements
Module: minmax_reduce_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element width (signed two's complement).
REQ-002 SHALL have parameter CNT_W, default 8, width of the element-count and index fields.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1, begin a reduction; sampled only in IDLE.
REQ-006 SHALL have port mode_max, input, 1, reduction select latched with start (0 = signed min, 1 = signed max).
REQ-007 SHALL have port len, input, CNT_W, number of elements, latched with start.
REQ-008 SHALL have port in_valid, input, 1, element offered.
REQ-009 SHALL have port in_data, input, WIDTH, signed element.
REQ-010 SHALL have port in_ready, output, 1, element accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high.
REQ-013 SHALL have port out_data, output, WIDTH, reduction result.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-016 IDLE: start=1 and len!=0 SHALL go to ACCUM; start=1 and len=0 SHALL go to DONE with acc loaded with the identity value.
REQ-017 Identity value SHALL be 0x7FFF for min and 0x8000 for max (WIDTH=16; generally the signed extreme).
REQ-018 start SHALL load acc with the identity value, clear the element counter and latch mode_max and len.
REQ-019 in_ready SHALL equal (state==ACCUM); there is no combinational path from in_valid to in_ready.
REQ-020 Each accepted element SHALL replace acc on the same edge when the element is strictly less than acc (min) or strictly greater than acc (max), using signed compare; on ties acc SHALL keep the earlier value.
REQ-021 Accepting the len-th element SHALL move the FSM to DONE on the same edge; out_valid SHALL be 1 in the following cycle (one-cycle result latency).
REQ-022 Throughput SHALL be one element per cycle while in_valid is held high; cycles with in_valid=0 SHALL be stalls with no state change.
REQ-023 DONE: out_valid=1 and out_data=acc SHALL be held stable until out_ready=1; the handshake edge SHALL return the FSM to IDLE.
REQ-024 start asserted outside IDLE SHALL be ignored; start in the same cycle as the DONE handshake SHALL be ignored (IDLE is re-entered first).
REQ-025 Changes to mode_max or len after start SHALL have no effect on the reduction in progress.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, acc=0, counter=0, out_valid=0, in_ready=0, busy=0, out_data=0, regardless of the current state.
REQ-027 Reset mid-reduction SHALL discard partial results; the first reduction after reset SHALL behave as the first after power-up.

Configuration
REQ-028 Macro MINMAX_REDUCE_ARGIDX_EN SHALL, when defined, add output out_idx [CNT_W-1:0]: the zero-based arrival index of the element held in acc, updated together with acc, 0 on start and on reset, and valid with out_valid.
REQ-029 Without MINMAX_REDUCE_ARGIDX_EN, out_idx and its register SHALL be absent, with all other behaviour identical.

Verification
REQ-030 min with len=4 and data 5, -3, 7, -3 -> out_data=0xFFFD (-3); out_idx=1 (the first occurrence wins); out_valid is first seen 1 cycle after the 4th accept.
REQ-031 max with len=3 and data 0x8000, 0x7FFF, 0x0000 -> out_data=0x7FFF; out_idx=1.
REQ-032 start with len=0 and min -> DONE on the next edge with out_data=0x7FFF, out_idx=0, and in_ready never high.
REQ-033 len=5 with in_valid toggled 1,0,1,0,... and out_ready held 0 for 3 cycles -> correct min of the 5 elements; out_data is stable while waiting; IDLE is reached one edge after out_ready=1.
REQ-034 rst_n=0 after 2 of 4 elements, then a new start with len=2 and data 10, 9 -> out_data=9 with no influence from the earlier elements.
REQ-035 start pulsed while busy and mode_max/len changed mid-run -> the running reduction is unaffected and no second reduction begins.
